// File: rtl/ahbl_ram_ws.sv
// ahbl_ram_ws: AHB-Lite RAM slave with a fixed number of wait states per data phase.
// Build option: define AHBL_RAM_ERR_EN to add size/alignment/range checking with
// the two-cycle ERROR response; without it the word index wraps and HRESP is tied OKAY.
module ahbl_ram_ws #(
    parameter int unsigned MEM_WORDS   = 2048,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID          = 32'hABCD_EF00
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

`ifdef AHBL_RAM_ERR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LAST} state_t;
`endif

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] idx_q;
    logic [3:0]    lanes_q;
    logic          write_q;

    logic          accept;
    logic [3:0]    lanes_d;
    logic [31:0]   mem [MEM_WORDS];

    assign accept = HREADY & HSEL & HTRANS[1];

    // Byte lanes touched by the transfer currently offered on the address bus
    always_comb begin
        lanes_d = 4'b1111;
        if (HSIZE == 3'd0)
            lanes_d = 4'b0001 << HADDR[1:0];
        else if (HSIZE == 3'd1)
            lanes_d = HADDR[1] ? 4'b1100 : 4'b0011;
    end

`ifdef AHBL_RAM_ERR_EN
    logic addr_err;

    // Flag unsupported sizes, misaligned half-words/words and addresses past the array
    always_comb begin
        addr_err = (HSIZE > 3'd2)
                || (HSIZE == 3'd1 && HADDR[0])
                || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                || (HADDR[31:AW+2] != '0);
    end

    // ID only labels this slave in simulation logs
    logic unused_id;
    assign unused_id = ^ID;
`else
    // Upper address bits are ignored (index wraps); ID only labels this slave in logs
    logic unused_bits;
    assign unused_bits = ^{ID, HADDR[31:AW+2]};
    assign HRESP = 1'b0;
`endif

    // Transfer sequencing; HREADYOUT/HRESP are registered alongside the next state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            idx_q     <= '0;
            lanes_q   <= '0;
            write_q   <= 1'b0;
            HREADYOUT <= 1'b1;
`ifdef AHBL_RAM_ERR_EN
            HRESP     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= ST_LAST;
                        HREADYOUT <= 1'b1;
                    end
                end
`ifdef AHBL_RAM_ERR_EN
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                end
`endif
                default: begin
                    // IDLE, LAST and ERR2 are the cycles where a new address phase can land
                    if (HREADY) begin
                        if (accept) begin
                            idx_q   <= HADDR[AW+1:2];
                            lanes_q <= lanes_d;
                            write_q <= HWRITE;
`ifdef AHBL_RAM_ERR_EN
                            HRESP   <= addr_err;
                            if (addr_err) begin
                                state     <= ST_ERR1;
                                write_q   <= 1'b0;
                                HREADYOUT <= 1'b0;
                            end else
`endif
                            if (WAIT_STATES != 0) begin
                                state     <= ST_WAIT;
                                wait_cnt  <= 4'(WAIT_STATES);
                                HREADYOUT <= 1'b0;
                            end else begin
                                state     <= ST_LAST;
                                HREADYOUT <= 1'b1;
                            end
                        end else begin
                            state     <= ST_IDLE;
                            write_q   <= 1'b0;
                            HREADYOUT <= 1'b1;
`ifdef AHBL_RAM_ERR_EN
                            HRESP     <= 1'b0;
`endif
                        end
                    end
                end
            endcase
        end
    end

    // Commit write lanes at the edge ending LAST; storage itself is never reset
    always_ff @(posedge HCLK) begin
        if (state == ST_LAST && write_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (lanes_q[b])
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Full stored word during a read LAST cycle, zero otherwise
    always_comb begin
        HRDATA = '0;
        if (state == ST_LAST && !write_q)
            HRDATA = mem[idx_q];
    end

endmodule

// File: tb/tb_ahbl_ram_ws.sv
// tb_ahbl_ram_ws: randomized AHB-Lite master against a transaction-level RAM model.
module tb_ahbl_ram_ws;
    localparam int unsigned MW     = 64;
    localparam int unsigned WS     = 3;
    localparam logic [31:0] SLV_ID = 32'h5A5A_0001;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic [1:0]  HTRANS  = 2'b00;
    logic [2:0]  HSIZE   = 3'd0;
    logic        HWRITE  = 1'b0;
    logic [31:0] HWDATA  = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahbl_ram_ws #(.MEM_WORDS(MW), .WAIT_STATES(WS), .ID(SLV_ID)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each cycle of the bus is one expected response; an accepted transfer
    // appends its whole data phase to the queue.
    typedef struct {
        bit          rdy;
        bit          resp;
        bit          rd;
        bit          wr;
        int unsigned idx;
        logic [3:0]  mask;
    } ph_t;

    ph_t         exp_q[$];
    ph_t         cur;
    logic [31:0] mem_m [MW];
    logic [31:0] exp_rd;

    function automatic ph_t mk_ph(bit rdy, bit resp, bit rd, bit wr, int unsigned idx, logic [3:0] mask);
        ph_t p;
        p.rdy = rdy; p.resp = resp; p.rd = rd; p.wr = wr; p.idx = idx; p.mask = mask;
        return p;
    endfunction

    function automatic logic [3:0] lane_mask(logic [2:0] sz, logic [31:0] a);
        int unsigned nb, first;
        logic [3:0] m;
        nb    = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        first = (sz == 0) ? a % 4 : (sz == 1) ? (a % 4) / 2 * 2 : 0;
        m = '0;
        for (int unsigned b = 0; b < 4; b++)
            if (b >= first && b < first + nb) m[b] = 1'b1;
        return m;
    endfunction

    function automatic bit is_err(logic [2:0] sz, logic [31:0] a);
`ifdef AHBL_RAM_ERR_EN
        return (sz > 2) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a / 4 >= MW);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            exp_q.delete();
            cur = mk_ph(1, 0, 0, 0, 0, '0);
        end else begin
            if (cur.wr) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (cur.mask[b]) mem_m[cur.idx][8*b +: 8] = HWDATA[8*b +: 8];
                $display("[%08h] write data %08h lanes %04b byte addr %08h",
                         SLV_ID, HWDATA, cur.mask, cur.idx * 4);
            end
            if (cur.rdy && HSEL && HTRANS[1]) begin
                if (is_err(HSIZE, HADDR)) begin
                    exp_q.push_back(mk_ph(0, 1, 0, 0, 0, '0));
                    exp_q.push_back(mk_ph(1, 1, 0, 0, 0, '0));
                end else begin
                    for (int unsigned i = 0; i < WS; i++)
                        exp_q.push_back(mk_ph(0, 0, 0, 0, 0, '0));
                    exp_q.push_back(mk_ph(1, 0, !HWRITE, HWRITE, (HADDR / 4) % MW,
                                          lane_mask(HSIZE, HADDR)));
                end
            end
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : mk_ph(1, 0, 0, 0, 0, '0);
        end
    end

    // Per-cycle comparison of the three slave outputs against the model
    always @(negedge HCLK) begin
        if (HRESETn) begin
            exp_rd = cur.rd ? mem_m[cur.idx] : 32'h0;
            check("hreadyout", 32'(HREADYOUT), 32'(cur.rdy));
            check("hresp", 32'(HRESP), 32'(cur.resp));
            check("hrdata", HRDATA, exp_rd);
        end
    end

    // ---------------- master driver ----------------
    logic        dp_wr = 1'b0;
    logic [31:0] dp_wd = '0;

    // Present one address phase; hold it until accepted. Returns the read data and
    // the number of wait cycles of the data phase that completed meanwhile.
    task automatic step(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic [2:0] size, input logic wr, input logic [31:0] wd,
                        output logic [31:0] rdata, output int unsigned waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        HSEL = sel; HTRANS = trans; HADDR = addr; HSIZE = size; HWRITE = wr;
        for (int unsigned c = 0; c < 40 && !done; c++) begin
            if (HREADYOUT) begin
                HWDATA = dp_wr ? dp_wd : $urandom;
                rdata  = HRDATA;
                done   = 1'b1;
            end else begin
                HWDATA = $urandom;
                waits++;
            end
            @(posedge HCLK);
            #1;
        end
        check("step_accepted", 32'(done), 32'd1);
        dp_wr = sel && trans[1] && wr;
        dp_wd = wd;
    endtask

    function automatic logic [31:0] init_pat(int unsigned i);
        return 32'h1000_0000 + i * 32'h0103_0507;
    endfunction

    logic [31:0]  rd;
    int unsigned  wt;

    initial begin
        cur = mk_ph(1, 0, 0, 0, 0, '0);
        #1 HRESETn = 1'b0;
        #1;
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        for (int unsigned i = 0; i < MW; i++)
            step(1, 2'b10, i * 4, 3'd2, 1, init_pat(i), rd, wt);

        // word write then read, with wait states and junk HWDATA during waits
        step(1, 2'b10, 32'h10, 3'd2, 1, 32'hDEAD_BEEF, rd, wt);
        step(1, 2'b10, 32'h10, 3'd2, 0, 32'h0, rd, wt);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("rd_deadbeef", rd, 32'hDEAD_BEEF);
        check("rd_waits", wt, 32'd3);

        // byte and half-word lane merges
        step(1, 2'b10, 32'h10, 3'd2, 1, 32'h1122_3344, rd, wt);
        step(1, 2'b10, 32'h13, 3'd0, 1, 32'hAAAA_AAAA, rd, wt);
        step(1, 2'b10, 32'h10, 3'd2, 0, 32'h0, rd, wt);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("rd_byte_merge", rd, 32'hAA22_3344);
        step(1, 2'b10, 32'h10, 3'd1, 1, 32'h5566_5566, rd, wt);
        step(1, 2'b10, 32'h10, 3'd2, 0, 32'h0, rd, wt);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("rd_half_merge", rd, 32'hAA22_5566);

        // misaligned word write
        step(1, 2'b10, 32'h12, 3'd2, 1, 32'h7777_7777, rd, wt);
`ifdef AHBL_RAM_ERR_EN
        check("err1_hresp", 32'(HRESP), 32'd1);
        check("err1_hreadyout", 32'(HREADYOUT), 32'd0);
        step(1, 2'b10, 32'h10, 3'd2, 0, 32'h0, rd, wt);
        check("err_waits", wt, 32'd1);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("err_no_write", rd, 32'hAA22_5566);
`else
        check("miswr_hresp", 32'(HRESP), 32'd0);
        check("miswr_hreadyout", 32'(HREADYOUT), 32'd0);
        step(1, 2'b10, 32'h10, 3'd2, 0, 32'h0, rd, wt);
        check("miswr_waits", wt, 32'd3);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("miswr_written", rd, 32'h7777_7777);
`endif

        // back-to-back write then read
        step(1, 2'b10, 32'h40, 3'd2, 1, 32'h0102_0304, rd, wt);
        step(1, 2'b10, 32'h40, 3'd2, 0, 32'h0, rd, wt);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("rd_b2b", rd, 32'h0102_0304);

        // reset in the middle of a write's wait states
        step(1, 2'b10, 32'h20, 3'd2, 1, 32'hCAFE_F00D, rd, wt);
        HSEL = 1'b0; HTRANS = 2'b00;
        #2 HRESETn = 1'b0;
        #1;
        check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("midrst_hresp", 32'(HRESP), 32'd0);
        check("midrst_hrdata", HRDATA, 32'd0);
        @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        dp_wr = 1'b0;
        @(posedge HCLK);
        #1;
        step(1, 2'b10, 32'h20, 3'd2, 0, 32'h0, rd, wt);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        check("rd_after_abort", rd, init_pat(8));

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int unsigned k;
            logic [31:0] a;
            logic [2:0]  sz;
            logic        w;
            k  = $urandom_range(0, 9);
            w  = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 2));
            if (k == 0)
                step(1, 2'b00, $urandom, sz, w, $urandom, rd, wt);
            else if (k == 1)
                step(1, 2'b01, $urandom, sz, w, $urandom, rd, wt);
            else if (k == 2)
                step(0, 2'b10, $urandom, sz, w, $urandom, rd, wt);
            else begin
                if (k == 9) begin
                    a  = $urandom;
                    sz = 3'($urandom_range(0, 3));
                end else begin
                    a = $urandom_range(0, MW - 1) * 4;
                    if (sz == 0) a = a + $urandom_range(0, 3);
                    else if (sz == 1) a = a + 2 * $urandom_range(0, 1);
                end
                step(1, (k % 2 == 0) ? 2'b10 : 2'b11, a, sz, w, $urandom, rd, wt);
            end
        end
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        step(0, 2'b00, 32'h0, 3'd0, 0, 32'h0, rd, wt);
        @(negedge HCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
